// File: rtl/ttl_pkg.sv
// Shared constants for the 74x-style counter family.
//   SLICE_W  : width of one counter slice (one nibble)
//   DIR_UP   : value of 'down' that selects counting up
//   DIR_DOWN : value of 'down' that selects counting down
package ttl_pkg;

  localparam int   SLICE_W  = 4;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ttl74x191_slice.sv
// One 4-bit synchronous presettable up/down counter slice.
// Ports:
//   clock   : rising-edge clock
//   clr     : asynchronous active-low reset (q -> 0)
//   load    : synchronous parallel load, active-low (highest priority)
//   ent     : count enable / carry-borrow in; also gates rco
//   enp     : parallel count enable; does not gate rco
//   down    : 0 = count up, 1 = count down
//   d       : parallel load data
//   q       : slice value
//   max_min : terminal count for the current direction (ungated)
//   rco     : ent & max_min, feeds the next slice's ent
module ttl74x191_slice
  import ttl_pkg::*;
(
  input  logic               clock,
  input  logic               clr,
  input  logic               load,
  input  logic               ent,
  input  logic               enp,
  input  logic               down,
  input  logic [SLICE_W-1:0] d,
  output logic [SLICE_W-1:0] q,
  output logic               max_min,
  output logic               rco
);

  logic [SLICE_W-1:0] q_q;
  logic [SLICE_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!load) begin
      q_d = d;
    end else if (ent && enp) begin
      if (down == DIR_DOWN) begin
        q_d = q_q - 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Terminal value is all-ones going up and zero going down; tracks 'down'
  // combinationally so a direction change is visible in the same cycle.
  assign max_min = (down == DIR_DOWN) ? (q_q == '0) : (q_q == '1);
  assign rco     = ent & max_min;
  assign q       = q_q;

endmodule

// File: rtl/ttl74x191.sv
// WIDTH-bit synchronous presettable up/down counter built from 4-bit slices
// chained through rco, plus a registered wrap pulse.
// Ports:
//   clock   : rising-edge clock
//   clr     : asynchronous active-low reset (q -> 0, wrap -> 0)
//   load    : synchronous parallel load, active-low
//   ent     : count enable / carry-borrow in; also gates rco
//   enp     : parallel count enable; does not gate rco
//   down    : 0 = count up, 1 = count down
//   d       : parallel load data
//   q       : counter value
//   max_min : full-width terminal count for the current direction
//   rco     : ent & max_min (rco of the MSB slice)
//   wrap    : one-cycle pulse after a counting edge that wrapped
module ttl74x191
  import ttl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic             ent,
  input  logic             enp,
  input  logic             down,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             max_min,
  output logic             rco,
  output logic             wrap
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("ttl74x191: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [NUM_SLICES-1:0] slice_ent;
  logic [NUM_SLICES-1:0] slice_rco;
  logic [NUM_SLICES-1:0] slice_max_min;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      // Each slice counts only when every lower slice sits at its terminal
      // value; the chained rco carries the AND of ent and those conditions.
      if (gi == 0) begin : g_first
        assign slice_ent[gi] = ent;
      end else begin : g_rest
        assign slice_ent[gi] = slice_rco[gi-1];
      end

      ttl74x191_slice u_slice (
        .clock   (clock),
        .clr     (clr),
        .load    (load),
        .ent     (slice_ent[gi]),
        .enp     (enp),
        .down    (down),
        .d       (d[gi*SLICE_W +: SLICE_W]),
        .q       (q[gi*SLICE_W +: SLICE_W]),
        .max_min (slice_max_min[gi]),
        .rco     (slice_rco[gi])
      );
    end
  endgenerate

  assign max_min = &slice_max_min;
  assign rco     = slice_rco[NUM_SLICES-1];

  // A counting edge taken from the full-width terminal value is exactly a wrap.
  logic wrap_q;
  logic wrap_d;

  always_comb begin
    wrap_d = load & ent & enp & max_min;
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_ttl74x191.sv
// Directed self-checking bench for ttl74x191 at WIDTH = 4 and WIDTH = 8.
module tb_ttl74x191;

  logic       clock = 1'b0;
  logic       clr   = 1'b0;
  logic       load  = 1'b1;
  logic       ent   = 1'b0;
  logic       enp   = 1'b0;
  logic       down  = 1'b0;
  logic [3:0] d4    = 4'h0;
  logic [7:0] d8    = 8'h00;

  logic [3:0] q4;
  logic       max_min4, rco4, wrap4;
  logic [7:0] q8;
  logic       max_min8, rco8, wrap8;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ttl74x191 #(.WIDTH(4)) dut4 (
    .clock(clock), .clr(clr), .load(load), .ent(ent), .enp(enp), .down(down),
    .d(d4), .q(q4), .max_min(max_min4), .rco(rco4), .wrap(wrap4)
  );

  ttl74x191 #(.WIDTH(8)) dut8 (
    .clock(clock), .clr(clr), .load(load), .ent(ent), .enp(enp), .down(down),
    .d(d8), .q(q8), .max_min(max_min8), .rco(rco8), .wrap(wrap8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; #12;
    clr = 1'b1;
    load = 1'b0; d4 = 4'h9; down = 1'b0; ent = 1'b1; enp = 1'b1;
    tick();
    load = 1'b1; down = 1'b1;
    checks++; if (q4 !== 4'h9) begin failures++; $display("FAIL reset_preload q=%h exp=%h", q4, 4'h9); end
    #3;
    clr = 1'b0; #1;
    checks++; if (q4 !== 4'h0) begin failures++; $display("FAIL reset_async_q q=%h exp=%h", q4, 4'h0); end
    checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL reset_async_wrap wrap=%b exp=0", wrap4); end
    checks++; if (max_min4 !== 1'b1) begin failures++; $display("FAIL reset_max_min got=%b exp=1", max_min4); end
    checks++; if (rco4 !== 1'b1) begin failures++; $display("FAIL reset_rco got=%b exp=1", rco4); end
    tick();
    checks++; if (q4 !== 4'h0) begin failures++; $display("FAIL reset_held q=%h exp=%h", q4, 4'h0); end
    clr = 1'b1;
    tick();
    checks++; if (q4 !== 4'hF) begin failures++; $display("FAIL reset_first_edge q=%h exp=%h", q4, 4'hF); end
    $display("test_reset: q=%h", q4);
  endtask

  task automatic test_up();
    load = 1'b0; d4 = 4'hE; down = 1'b0; ent = 1'b1; enp = 1'b1;
    tick();
    load = 1'b1; #1;
    checks++; if (q4 !== 4'hE || rco4 !== 1'b0 || wrap4 !== 1'b0) begin failures++; $display("FAIL up_load q=%h rco=%b wrap=%b exp=e 0 0", q4, rco4, wrap4); end
    tick();
    checks++; if (q4 !== 4'hF || rco4 !== 1'b1 || wrap4 !== 1'b0) begin failures++; $display("FAIL up_f q=%h rco=%b wrap=%b exp=f 1 0", q4, rco4, wrap4); end
    tick();
    checks++; if (q4 !== 4'h0 || rco4 !== 1'b0 || wrap4 !== 1'b1) begin failures++; $display("FAIL up_wrap q=%h rco=%b wrap=%b exp=0 0 1", q4, rco4, wrap4); end
    tick();
    checks++; if (q4 !== 4'h1 || rco4 !== 1'b0 || wrap4 !== 1'b0) begin failures++; $display("FAIL up_1 q=%h rco=%b wrap=%b exp=1 0 0", q4, rco4, wrap4); end
    $display("test_up: q=%h", q4);
  endtask

  task automatic test_down();
    load = 1'b0; d4 = 4'h1; down = 1'b1; ent = 1'b1; enp = 1'b1;
    tick();
    load = 1'b1; #1;
    checks++; if (q4 !== 4'h1 || rco4 !== 1'b0) begin failures++; $display("FAIL down_load q=%h rco=%b exp=1 0", q4, rco4); end
    tick();
    checks++; if (q4 !== 4'h0 || rco4 !== 1'b1 || wrap4 !== 1'b0) begin failures++; $display("FAIL down_0 q=%h rco=%b wrap=%b exp=0 1 0", q4, rco4, wrap4); end
    tick();
    checks++; if (q4 !== 4'hF || rco4 !== 1'b0 || wrap4 !== 1'b1) begin failures++; $display("FAIL down_wrap q=%h rco=%b wrap=%b exp=f 0 1", q4, rco4, wrap4); end
    tick();
    checks++; if (q4 !== 4'hE || rco4 !== 1'b0 || wrap4 !== 1'b0) begin failures++; $display("FAIL down_e q=%h rco=%b wrap=%b exp=e 0 0", q4, rco4, wrap4); end
    $display("test_down: q=%h", q4);
  endtask

  task automatic test_enables();
    load = 1'b0; d4 = 4'hF; down = 1'b0; ent = 1'b1; enp = 1'b1;
    tick();
    checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL load_terminal_wrap wrap=%b exp=0", wrap4); end
    load = 1'b1; enp = 1'b0; #1;
    checks++; if (rco4 !== 1'b1) begin failures++; $display("FAIL enp_rco rco=%b exp=1", rco4); end
    tick();
    checks++; if (q4 !== 4'hF || wrap4 !== 1'b0) begin failures++; $display("FAIL enp_hold q=%h wrap=%b exp=f 0", q4, wrap4); end
    ent = 1'b0; enp = 1'b1; #1;
    checks++; if (rco4 !== 1'b0 || max_min4 !== 1'b1) begin failures++; $display("FAIL ent_rco rco=%b max_min=%b exp=0 1", rco4, max_min4); end
    tick();
    checks++; if (q4 !== 4'hF) begin failures++; $display("FAIL ent_hold q=%h exp=f", q4); end
    load = 1'b0; d4 = 4'h5; ent = 1'b1; enp = 1'b1;
    tick();
    checks++; if (q4 !== 4'h5 || wrap4 !== 1'b0) begin failures++; $display("FAIL load_wins q=%h wrap=%b exp=5 0", q4, wrap4); end
    load = 1'b1;
    $display("test_enables: q=%h", q4);
  endtask

  task automatic test_direction();
    load = 1'b0; d4 = 4'h7; down = 1'b0; ent = 1'b1; enp = 1'b1;
    tick();
    load = 1'b1; #2;
    down = 1'b1;
    tick();
    checks++; if (q4 !== 4'h6) begin failures++; $display("FAIL dir_flip_1 q=%h exp=6", q4); end
    tick();
    checks++; if (q4 !== 4'h5) begin failures++; $display("FAIL dir_flip_2 q=%h exp=5", q4); end
    load = 1'b0; d4 = 4'h0;
    tick();
    load = 1'b1; enp = 1'b0; down = 1'b1; #1;
    checks++; if (max_min4 !== 1'b1) begin failures++; $display("FAIL dir_mm_down got=%b exp=1", max_min4); end
    down = 1'b0; #1;
    checks++; if (max_min4 !== 1'b0) begin failures++; $display("FAIL dir_mm_up got=%b exp=0", max_min4); end
    $display("test_direction: q=%h", q4);
  endtask

  task automatic test_cascade();
    load = 1'b0; d8 = 8'hFF; down = 1'b0; ent = 1'b1; enp = 1'b1;
    tick();
    load = 1'b1; #1;
    checks++; if (q8 !== 8'hFF || rco8 !== 1'b1 || max_min8 !== 1'b1) begin failures++; $display("FAIL casc_ff q=%h rco=%b mm=%b exp=ff 1 1", q8, rco8, max_min8); end
    tick();
    checks++; if (q8 !== 8'h00 || wrap8 !== 1'b1) begin failures++; $display("FAIL casc_wrap_up q=%h wrap=%b exp=00 1", q8, wrap8); end
    tick();
    checks++; if (q8 !== 8'h01 || wrap8 !== 1'b0) begin failures++; $display("FAIL casc_after q=%h wrap=%b exp=01 0", q8, wrap8); end
    load = 1'b0; d8 = 8'h0F;
    tick();
    load = 1'b1; #1;
    checks++; if (rco8 !== 1'b0) begin failures++; $display("FAIL casc_0f_rco rco=%b exp=0", rco8); end
    tick();
    checks++; if (q8 !== 8'h10 || wrap8 !== 1'b0) begin failures++; $display("FAIL casc_carry q=%h wrap=%b exp=10 0", q8, wrap8); end
    load = 1'b0; d8 = 8'h10; down = 1'b1;
    tick();
    load = 1'b1;
    tick();
    checks++; if (q8 !== 8'h0F || wrap8 !== 1'b0 || rco8 !== 1'b0) begin failures++; $display("FAIL casc_borrow q=%h wrap=%b rco=%b exp=0f 0 0", q8, wrap8, rco8); end
    load = 1'b0; d8 = 8'h00;
    tick();
    load = 1'b1; #1;
    checks++; if (rco8 !== 1'b1) begin failures++; $display("FAIL casc_00_rco rco=%b exp=1", rco8); end
    tick();
    checks++; if (q8 !== 8'hFF || wrap8 !== 1'b1) begin failures++; $display("FAIL casc_wrap_down q=%h wrap=%b exp=ff 1", q8, wrap8); end
    $display("test_cascade: q=%h", q8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_up();
    test_down();
    test_enables();
    test_direction();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl74x191.md
Name: ttl74x191

Overview:
- Synchronous, presettable binary up/down counter modelled on the 74x191.
- It is the counting-down companion to the team's 74x163-style up-counter, and uses the same ent/enp/rco cascade convention so the two parts can sit side by side on the CPU datapath.
- Used for stack pointers, loop counters and decrementing address registers.
- Built from 4-bit slices cascaded through rco, so wider counters need no glue logic.

Parameters:
- WIDTH, 4, counter width in bits; must be a multiple of 4 (one slice per nibble); elaboration error otherwise.

Ports:
- clock  input  1  rising-edge clock
- clr  input  1  reset; asynchronous, active-low
- load  input  1  synchronous parallel load, active-low
- ent  input  1  count enable / carry-borrow in; also gates rco
- enp  input  1  count enable, parallel; does not gate rco
- down  input  1  direction: 0 = count up, 1 = count down
- d  input  WIDTH  parallel load data
- q  output  WIDTH  counter value
- max_min  output  1  terminal count, ungated: q == all-ones when down=0, q == 0 when down=1
- rco  output  1  ripple carry/borrow out = ent & max_min
- wrap  output  1  registered one-cycle pulse: counter wrapped on the previous edge

Behaviour:
- Reset is clr, asynchronous, active-low; clock is clock.
- On clr low: q = 0 and wrap = 0 immediately, independent of clock, and held while clr is low.
- After clr is released, max_min = down and rco = ent & down, because 0 is the down-terminal value.
- Priority at each rising edge with clr high: load low > count > hold.
- Load (load = 0): q <= d; wrap <= 0. ent, enp and down are ignored. Loading a terminal value does not pulse wrap.
- Count (load = 1, ent = 1, enp = 1):
  - down = 0: q <= q + 1 mod 2^WIDTH.
  - down = 1: q <= q - 1 mod 2^WIDTH.
  - wrap <= max_min, i.e. high for exactly the cycle after 0xF..F -> 0 (up) or 0 -> 0xF..F (down).
- Hold (otherwise): q unchanged; wrap <= 0.
- Latency: q changes one clock after the qualifying edge.
- max_min and rco are combinational from q, down and ent, so they track a change in down within the same cycle. A direction change takes effect on count at the next edge. No extra state; no glitch filtering required.
- Cascade: slice i ent = (ent & rco of slices 0..i-1), i.e. a chained rco. enp goes to all slices in parallel. The top-level rco is the rco of the MSB slice. The full-width counter must behave exactly as a single WIDTH-bit counter, including wrap.
- Simultaneous load and count enables: load wins.
- clr asserted mid-count or mid-load: reset wins; no partial update.
- clr deasserted near a clock edge: the first edge after release with clr high is a normal edge.
- No X propagation from d when load is high; q never depends on d except during a load.

Decomposition:
- Shared package ttl_pkg: SLICE_W = 4 and the direction constants DIR_UP = 1'b0, DIR_DOWN = 1'b1. This package is reused by the up-counter family.
- Sub-module ttl74x191_slice: a 4-bit up/down slice with clock, clr, load, ent, enp, down, d[3:0], q[3:0], max_min, rco.
- The top level generates WIDTH/4 slices and the rco chain, and registers wrap once at top level from the full-width terminal condition.

Test Plan:
- Reset: drive clr low mid-count at q = 0x9 -> q = 0x0 and wrap = 0 without a clock edge. With down = 1, ent = 1: max_min = 1 and rco = 1.
- Up count and wrap (WIDTH = 4): load 0xE, then ent = enp = 1, down = 0, 3 clocks -> q = 0xF, 0x0, 0x1. rco = 1 only while q = 0xF. wrap = 1 only in the cycle q = 0x0.
- Down count and wrap: load 0x1, down = 1, 3 clocks -> q = 0x0, 0xF, 0xE. rco = 1 only while q = 0x0. wrap = 1 only in the cycle q = 0xF.
- Enable qualifiers:
  - enp = 0, ent = 1, q = 0xF, down = 0 -> q holds and rco = 1.
  - ent = 0 -> q holds and rco = 0.
  - Load 0x5 with ent = enp = 1 and load = 0 -> q = 0x5 (load wins) and wrap = 0.
- Direction flip: q = 0x7 counting up, set down = 1 between edges -> next edges give 0x6, 0x5. With q = 0x0, toggling down toggles max_min combinationally (down = 1 -> 1, down = 0 -> 0).
- Cascade (WIDTH = 8):
  - Load 0x0FF, count up -> 0x00 carries into the upper slice giving 0x100 truncated to 8 bits (q = 0x00), with wrap = 1 only for the 0xFF -> 0x00 transition.
  - Load 0x10, count down -> 0x0F, with no wrap and rco = 0.
